kogge_sub_pipe: RTL and testbench

KOGGE_SUB_PIPE -- requirements
Module: kogge_sub_pipe

---
 rtl/kogge_pkg.sv | 27 ++
 rtl/kogge_prefix_level.sv | 31 +++
 rtl/kogge_sub_pipe.sv | 198 +++++++++++++++++++
 tb/tb_kogge_sub_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kogge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kogge_pkg
// Brief    : Shared constants, log2 helper and P/G pair type for the
//            Kogge-Stone subtractor.
// Revision : 1.0
// ============================================================================
package kogge_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int kogge_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kogge_prefix_level.sv
`default_nettype none
// ============================================================================
// Module   : kogge_prefix_level
// Brief    : One Kogge-Stone prefix level; bits at or above SPAN get a
//            black cell, lower bits already hold complete groups.
// Revision : 1.0
// ============================================================================
module kogge_prefix_level
  import kogge_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_black
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
      assign p_out[i] = p_in[i] & p_in[i-SPAN];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/kogge_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : kogge_sub_pipe
// Brief    : Two-stage valid/ready Kogge-Stone subtractor, D = A - B - Bin.
//            Define KOGGE_SUB_OVF_EN to add the signed-overflow output V.
// Revision : 1.0
// ============================================================================
module kogge_sub_pipe
  import kogge_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SPLIT = kogge_log2(WIDTH) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef KOGGE_SUB_OVF_EN
  output logic             V,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = kogge_log2(WIDTH);

  // ---------------------------------------------------------------- handshake
  logic r_v1;
  logic r_v2;
  logic w_ld1;
  logic w_ld2;

  assign w_ld2     = ~r_v2 | out_ready;
  assign w_ld1     = ~r_v1 | w_ld2;
  assign in_ready  = ~rst & w_ld1;
  assign out_valid = r_v2;

  // ------------------------------------------------- stage 1: A + ~B + ~Bin
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_g0;
  logic             w_cin;

  assign w_p   = A ^ ~B;
  assign w_g   = A & ~B;
  assign w_cin = ~Bin;
  // Carry-in folded into bit 0 so each final group G is the carry out of that bit.
  assign w_g0  = {w_g[WIDTH-1:1], w_g[0] | (w_p[0] & w_cin)};

  for (genvar k = 0; k < SPLIT; k++) begin : g_s1
    logic [WIDTH-1:0] w_g_in;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_out;
    logic [WIDTH-1:0] w_p_out;
    if (k == 0) begin : g_first
      assign w_g_in = w_g0;
      assign w_p_in = w_p;
    end else begin : g_next
      assign w_g_in = g_s1[k-1].w_g_out;
      assign w_p_in = g_s1[k-1].w_p_out;
    end
    kogge_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_level (
      .g_in  (w_g_in),
      .p_in  (w_p_in),
      .g_out (w_g_out),
      .p_out (w_p_out)
    );
  end

  logic [WIDTH-1:0] w_s1_g;
  logic [WIDTH-1:0] w_s1_p;

  if (SPLIT == 0) begin : g_s1_none
    assign w_s1_g = w_g0;
    assign w_s1_p = w_p;
  end else begin : g_s1_tail
    assign w_s1_g = g_s1[SPLIT-1].w_g_out;
    assign w_s1_p = g_s1[SPLIT-1].w_p_out;
  end

  pg_t [WIDTH-1:0] w_grp;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_grp[i].g = w_s1_g[i];
      w_grp[i].p = w_s1_p[i];
    end
  end

  pg_t [WIDTH-1:0] r_grp;
  logic [WIDTH-1:0] r_p_raw;
  logic             r_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
    end
    if (w_ld1 && in_valid) begin
      r_grp   <= w_grp;
      r_p_raw <= w_p;
      r_cin   <= w_cin;
    end
  end

  // ------------------------------------------- stage 2: remaining levels + sum
  logic [WIDTH-1:0] w_r_g;
  logic [WIDTH-1:0] w_r_p;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_r_g[i] = r_grp[i].g;
      w_r_p[i] = r_grp[i].p;
    end
  end

  for (genvar k = SPLIT; k < LEVELS; k++) begin : g_s2
    logic [WIDTH-1:0] w_g_in;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_out;
    logic [WIDTH-1:0] w_p_out;
    if (k == SPLIT) begin : g_first
      assign w_g_in = w_r_g;
      assign w_p_in = w_r_p;
    end else begin : g_next
      assign w_g_in = g_s2[k-1].w_g_out;
      assign w_p_in = g_s2[k-1].w_p_out;
    end
    kogge_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_level (
      .g_in  (w_g_in),
      .p_in  (w_p_in),
      .g_out (w_g_out),
      .p_out (w_p_out)
    );
  end

  logic [WIDTH-1:0] w_fin_g;
  logic [WIDTH-1:0] w_fin_p;

  if (LEVELS == SPLIT) begin : g_s2_none
    assign w_fin_g = w_r_g;
    assign w_fin_p = w_r_p;
  end else begin : g_s2_tail
    assign w_fin_g = g_s2[LEVELS-1].w_g_out;
    assign w_fin_p = g_s2[LEVELS-1].w_p_out;
  end

  // Whole-word group propagate has no consumer in a subtractor.
  logic w_unused_p;
  assign w_unused_p = ^w_fin_p;

  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_d;
  logic             w_bout;

  assign w_c    = {w_fin_g[WIDTH-2:0], r_cin};
  assign w_d    = r_p_raw ^ w_c;
  assign w_bout = ~w_fin_g[WIDTH-1];

`ifdef KOGGE_SUB_OVF_EN
  logic w_v;
  assign w_v = w_c[WIDTH-1] ^ w_fin_g[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef KOGGE_SUB_OVF_EN
      V    <= 1'b0;
`endif
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        D    <= w_d;
        Bout <= w_bout;
`ifdef KOGGE_SUB_OVF_EN
        V    <= w_v;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kogge_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_kogge_sub_pipe
// Brief    : Self-checking bench for kogge_sub_pipe (WIDTH=8) against an
//            arithmetic reference model and an in-order scoreboard.
// Revision : 1.0
// ============================================================================
module tb_kogge_sub_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] D;
  logic         Bout;
`ifdef KOGGE_SUB_OVF_EN
  logic         V;
`endif
  logic         out_valid;
  logic         out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kogge_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
`ifdef KOGGE_SUB_OVF_EN
    .V         (V),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // {borrow, difference} of the unsigned subtraction a - b - bi
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    int s;
    s = int'(a) - int'(b) - int'(bi);
    return {(s < 0), s[W-1:0]};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bin = 1'b0;
    tick(); tick(); tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_vec++;
    if ({Bout, D} !== 9'h000) begin n_err++; $display("FAIL reset_data got %h want 000", {Bout, D}); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask

  // One operand through an otherwise empty pipe, checking the 2-cycle latency.
  task automatic test_single(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bi);
    logic [W:0] exp;
    exp = ref_sub(a, b, bi);
    A = a; B = b; Bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready got %0b want 1", nm, in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s early_valid got %0b want 0", nm, out_valid); end
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s out_valid got %0b want 1", nm, out_valid); end
    n_vec++;
    if ({Bout, D} !== exp) begin
      n_err++; $display("FAIL %s result got Bout=%0b D=%h want Bout=%0b D=%h", nm, Bout, D, exp[W], exp[W-1:0]);
    end
`ifdef KOGGE_SUB_OVF_EN
    n_vec++;
    if (V !== ref_ovf(a, b, bi)) begin n_err++; $display("FAIL %s V got %0b want %0b", nm, V, ref_ovf(a, b, bi)); end
`endif
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s drain got %0b want 0", nm, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a[3];
    logic [W-1:0] b[3];
    logic         bi[3];
    for (int i = 0; i < 3; i++) begin
      a[i] = W'($urandom); b[i] = W'($urandom); bi[i] = 1'($urandom);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = a[i]; B = b[i]; Bin = bi[i]; in_valid = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== (i < 2)) begin n_err++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, in_ready, (i < 2)); end
      tick();
    end
    n_vec++;
    if ({out_valid, Bout, D} !== {1'b1, ref_sub(a[0], b[0], bi[0])}) begin
      n_err++; $display("FAIL bp_hold got v=%0b %h want v=1 %h", out_valid, {Bout, D}, ref_sub(a[0], b[0], bi[0]));
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if ({out_valid, Bout, D} !== {1'b1, ref_sub(a[i], b[i], bi[i])}) begin
        n_err++; $display("FAIL bp_order[%0d] got v=%0b %h want v=1 %h", i, out_valid, {Bout, D}, ref_sub(a[i], b[i], bi[i]));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [W:0] q[$];
    logic [W:0] exp;
    logic [W:0] held;
    logic       hold;
    int         sent;
    int         cycles;
    sent = 0; cycles = 0; hold = 1'b0; held = '0;
    while ((sent < 10000 || q.size() != 0) && cycles < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      #1;
      if (hold) begin
        n_vec++;
        if ({out_valid, Bout, D} !== {1'b1, held}) begin
          n_err++; $display("FAIL rnd_stable got v=%0b %h want v=1 %h", out_valid, {Bout, D}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious got %h want none", {Bout, D});
        end else begin
          exp = q.pop_front();
          if ({Bout, D} !== exp) begin
            n_err++; $display("FAIL rnd_result got %h want %h", {Bout, D}, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(A, B, Bin));
        sent++;
      end
      hold = out_valid && !out_ready;
      held = {Bout, D};
      tick();
      cycles++;
    end
    n_vec++;
    if (q.size() != 0 || sent != 10000) begin
      n_err++; $display("FAIL rnd_timeout got sent=%0d pending=%0d want sent=10000 pending=0", sent, q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
    n_vec++;
    if ({Bout, D} !== 9'h000) begin n_err++; $display("FAIL midrst_data got %h want 000", {Bout, D}); end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale[%0d] got %0b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single("case1", 8'h05, 8'h03, 1'b0);
    test_single("case2a", 8'h03, 8'h05, 1'b0);
    test_single("case2b", 8'h00, 8'h00, 1'b1);
    test_single("max_minus_zero", 8'hFF, 8'h00, 1'b0);
    test_single("zero_minus_max", 8'h00, 8'hFF, 1'b1);
`ifdef KOGGE_SUB_OVF_EN
    test_single("ovf_neg", 8'h80, 8'h01, 1'b0);
    test_single("ovf_none", 8'h7F, 8'h01, 1'b0);
`endif
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_single("after_reset", 8'hA5, 8'h5A, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
